// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative unsigned multiply/divide unit for the EX stage.
// Performs a radix-2 shift-add multiply or a restoring divide, one bit per
// clock, over DATA_WIDTH cycles. busy stalls the front of the pipeline while
// iterating; done pulses for one cycle with result and rd_out for EX/MEM.
//
// Ports:
//   clk     pipeline clock, all state updates on posedge
//   rst     asynchronous, active-low reset
//   start   ID/EX holds a valid mul/div instruction
//   op      00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   src_a   multiplicand / dividend
//   src_b   multiplier / divisor
//   rd_in   destination register from ID/EX
//   flush   aborts the operation in flight
//   busy    unit occupied (registered, high exactly while iterating)
//   done    one-cycle pulse, result and rd_out valid
//   result  selected result
//   rd_out  destination register of the completed operation
module ex_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic [4:0]            rd_in,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [4:0]            rd_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [1:0]              op_q;
  logic [4:0]              rd_q;
  logic [DATA_WIDTH-1:0]   acc_hi;   // product high half / partial remainder
  logic [DATA_WIDTH-1:0]   acc_lo;   // multiplier->product low / dividend->quotient
  logic [DATA_WIDTH-1:0]   opnd;     // multiplicand or divisor
  logic [2*DATA_WIDTH-1:0] step;
  logic [DATA_WIDTH-1:0]   step_hi;
  logic [DATA_WIDTH-1:0]   step_lo;
  logic                    accept;

  // One shift-add step: conditionally add the multiplicand to the high half,
  // then shift the whole {carry, hi, lo} right by one.
  function automatic logic [2*DATA_WIDTH-1:0] mul_step(
    input logic [DATA_WIDTH-1:0] hi,
    input logic [DATA_WIDTH-1:0] lo,
    input logic [DATA_WIDTH-1:0] mcand
  );
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(DATA_WIDTH+1){1'b0}});
    return {sum, lo[DATA_WIDTH-1:1]};
  endfunction

  // One restoring-divide step: shift the next dividend bit into the partial
  // remainder, subtract the divisor if it fits and record the quotient bit.
  // The remainder stays below the divisor, so DATA_WIDTH bits always hold it.
  function automatic logic [2*DATA_WIDTH-1:0] div_step(
    input logic [DATA_WIDTH-1:0] hi,
    input logic [DATA_WIDTH-1:0] lo,
    input logic [DATA_WIDTH-1:0] dvsr
  );
    logic [DATA_WIDTH:0] sh;
    logic                ge;
    sh = {hi, lo[DATA_WIDTH-1]};
    ge = (sh >= {1'b0, dvsr});
    if (ge) sh = sh - {1'b0, dvsr};
    return {sh[DATA_WIDTH-1:0], lo[DATA_WIDTH-2:0], ge};
  endfunction

  always_comb begin
    step    = op_q[1] ? div_step(acc_hi, acc_lo, opnd) : mul_step(acc_hi, acc_lo, opnd);
    step_hi = step[2*DATA_WIDTH-1:DATA_WIDTH];
    step_lo = step[DATA_WIDTH-1:0];
  end

  assign accept = start && !flush && (state != RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
      cnt    <= '0;
      op_q   <= '0;
      rd_q   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              // MUL/DIVU take the low half, MULHU/REMU the high half.
              result <= op_q[0] ? step_hi : step_lo;
              rd_out <= rd_q;
            end
          end
        end
        default: begin  // IDLE and DONE both accept a new operation
          if (accept) begin
            op_q <= op;
            rd_q <= rd_in;
            cnt  <= '0;
            if (op[1] && (src_b == '0)) begin
              // Divide by zero skips iteration entirely.
              state  <= DONE;
              done   <= 1'b1;
              result <= op[0] ? src_a : '1;
              rd_out <= rd_in;
            end else begin
              state  <= RUN;
              busy   <= 1'b1;
              acc_hi <= '0;
              acc_lo <= op[1] ? src_a : src_b;
              opnd   <= op[1] ? src_b : src_a;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scoreboard bench for ex_muldiv_unit. Expected results are
// pushed when an operation is issued and popped when done pulses.
module tb_ex_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic [4:0]    rd_in = '0;
  logic          flush = 1'b0;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [4:0]    rd_out;

  ex_muldiv_unit #(.DATA_WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .rd_in(rd_in), .flush(flush), .busy(busy), .done(done), .result(result),
    .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   rd;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (o)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drives start for one edge. Call between a negedge and the next posedge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] rd, input bit exp_done);
    exp_t e;
    op = o; src_a = a; src_b = b; rd_in = rd; start = 1'b1;
    if (exp_done) begin
      e.res = model(o, a, b);
      e.rd  = rd;
      e.lat = (o[1] && b == 0) ? 1 : W + 1;
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the negedge where done is seen, counting busy cycles before it.
  task automatic wait_done(output int busy_cnt);
    bit got;
    got = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (busy) busy_cnt++;
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
        check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  int bc;

  initial begin
    #2 rst = 1'b0;
    #10;
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);

    issue(2'b00, 32'h0001_0000, 32'h0001_0000, 5'd5, 1'b1);
    wait_done(bc);
    check("mul_busy_cycles", 32'(bc), 32'd32);
    @(negedge clk);
    issue(2'b01, 32'h0001_0000, 32'h0001_0000, 5'd6, 1'b1); wait_done(bc); @(negedge clk);
    issue(2'b10, 32'd100, 32'd7, 5'd7, 1'b1);               wait_done(bc); @(negedge clk);
    issue(2'b11, 32'd100, 32'd7, 5'd8, 1'b1);               wait_done(bc); @(negedge clk);
    issue(2'b10, 32'hFFFF_FFFF, 32'd1, 5'd9, 1'b1);         wait_done(bc); @(negedge clk);
    issue(2'b11, 32'd3, 32'd10, 5'd10, 1'b1);               wait_done(bc); @(negedge clk);
    issue(2'b01, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd11, 1'b1); wait_done(bc); @(negedge clk);

    // Divide by zero
    issue(2'b10, 32'h1234, 32'd0, 5'd12, 1'b1);
    wait_done(bc);
    check("div0_busy_cycles", 32'(bc), 32'd0);
    @(negedge clk);
    issue(2'b11, 32'h1234, 32'd0, 5'd13, 1'b1); wait_done(bc); @(negedge clk);

    // Back-to-back: second start presented during the DONE cycle
    issue(2'b00, 32'd3, 32'd4, 5'd14, 1'b1);
    wait_done(bc);
    issue(2'b00, 32'd5, 32'd6, 5'd15, 1'b1);
    wait_done(bc);
    @(negedge clk);

    // Flush during the 10th RUN cycle of a divide
    issue(2'b10, 32'd1000, 32'd3, 5'd16, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    repeat (40) @(negedge clk);
    issue(2'b00, 32'd2, 32'd2, 5'd17, 1'b1); wait_done(bc); @(negedge clk);

    // start together with flush in IDLE is ignored
    start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    check("idle_flush_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);

    // Flush in DONE: the pulse stands, the new start is dropped
    issue(2'b00, 32'd2, 32'd3, 5'd18, 1'b1);
    wait_done(bc);
    start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd8; src_b = 32'd8;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    check("done_flush_busy", {31'd0, busy}, 32'd0);
    check("done_flush_done", {31'd0, done}, 32'd0);
    repeat (40) @(negedge clk);

    // Asynchronous reset between clock edges mid-RUN
    issue(2'b00, 32'd7, 32'd9, 5'd19, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy",   {31'd0, busy}, 32'd0);
    check("arst_done",   {31'd0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_rd_out", {27'd0, rd_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(2'b00, 32'd6, 32'd7, 5'd20, 1'b1); wait_done(bc);
    repeat (40) @(negedge clk);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
